// File: rtl/rv32i_lsu_pkg.sv
// Shared encodings for the RV32I load/store unit: FSM states, access sizes, lane masks, latched request.
// No logic of its own; the helpers below are pure combinational decode.
package rv32i_lsu_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_RESP  = 2'd2;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam logic [3:0] BE_BYTE    = 4'b0001;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_WORD    = 4'b1111;

    typedef struct packed {
        logic        is_store;
        logic [1:0]  size;
        logic        umload;
        logic [4:0]  rd;
        logic [31:0] addr;
        logic [31:0] wdata;
    } lsu_req_t;

    // Both wen and ren are ordered {word, half, byte}.
    function automatic logic [1:0] size_of(input logic [2:0] sel);
        if (sel[2])
            size_of = SZ_WORD;
        else if (sel[1])
            size_of = SZ_HALF;
        else
            size_of = SZ_BYTE;
    endfunction

    function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_BYTE: lane_be = BE_BYTE << off;
            SZ_HALF: lane_be = off[1] ? BE_HALF_HI : BE_HALF_LO;
            default: lane_be = BE_WORD;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_HALF: is_misaligned = off[0];
            SZ_WORD: is_misaligned = |off;
            default: is_misaligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/rv32i_lsu_load_align.sv
// Picks the addressed byte/half out of a read word and sign- or zero-extends it.
// Purely combinational, no backpressure.
module lsu_load_align
    import rv32i_lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [1:0]  size,
    input  logic        umload,
    output logic [31:0] data
);

    logic [7:0]  byte_dat;
    logic [15:0] half_dat;

    assign byte_dat = rdata[{addr, 3'b000} +: 8];
    assign half_dat = rdata[{addr[1], 4'b0000} +: 16];

    always_comb begin
        data = rdata;
        case (size)
            SZ_BYTE: data = {{24{byte_dat[7] & ~umload}}, byte_dat};
            SZ_HALF: data = {{16{half_dat[15] & ~umload}}, half_dat};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/rv32i_lsu.sv
// RV32I load/store unit: one outstanding dmem access, lane steering, load writeback, bus timeout.
// Latency: accept N, dmem_req N+1, earliest wb/st_done N+2; req_ready only in IDLE, nothing is queued.
module rv32i_lsu
    import rv32i_lsu_pkg::*;
#(
    parameter int ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  mem_wen,
    input  logic [2:0]  mem_ren,
    input  logic        umload,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [4:0]  rd_addr,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        st_done,
    output logic        misaligned,
    output logic        illegal,
    output logic        bus_err
);

    localparam int CW = $clog2(ACK_TIMEOUT + 1);

    logic [1:0]    state;
    lsu_req_t      req_q;
    lsu_req_t      acc_req;
    logic [31:0]   rdata_q;
    logic [CW-1:0] wait_cnt;
    logic [31:0]   store_lanes;

    always_comb begin
        acc_req          = '0;
        acc_req.is_store = |mem_wen;
        acc_req.size     = size_of(mem_wen | mem_ren);
        acc_req.umload   = umload;
        acc_req.rd       = rd_addr;
        acc_req.addr     = addr;
        acc_req.wdata    = wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            req_q      <= '0;
            rdata_q    <= '0;
            wait_cnt   <= '0;
            st_done    <= 1'b0;
            misaligned <= 1'b0;
            illegal    <= 1'b0;
            bus_err    <= 1'b0;
        end else begin
            st_done    <= 1'b0;
            misaligned <= 1'b0;
            illegal    <= 1'b0;
            bus_err    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        req_q    <= acc_req;
                        wait_cnt <= '0;
                        if (!$onehot({mem_wen, mem_ren}))
                            illegal <= 1'b1;
                        else if (is_misaligned(acc_req.size, addr[1:0]))
                            misaligned <= 1'b1;
                        else
                            state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (dmem_ack) begin
                        if (req_q.is_store) begin
                            st_done <= 1'b1;
                            state   <= ST_IDLE;
                        end else begin
                            rdata_q <= dmem_rdata;
                            state   <= ST_RESP;
                        end
                    end else if (wait_cnt == CW'(ACK_TIMEOUT - 1)) begin
                        // Abandon the access; the slave never answered.
                        bus_err <= 1'b1;
                        state   <= ST_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        case (req_q.size)
            SZ_BYTE: store_lanes = {4{req_q.wdata[7:0]}};
            SZ_HALF: store_lanes = {2{req_q.wdata[15:0]}};
            default: store_lanes = req_q.wdata;
        endcase
    end

    // Bus outputs are only meaningful while a request is on the wire; keep them quiet otherwise.
    assign req_ready  = (state == ST_IDLE);
    assign dmem_req   = (state == ST_ISSUE);
    assign dmem_we    = dmem_req & req_q.is_store;
    assign dmem_addr  = dmem_req ? {req_q.addr[31:2], 2'b00} : 32'h0;
    assign dmem_be    = dmem_req ? lane_be(req_q.size, req_q.addr[1:0]) : 4'h0;
    assign dmem_wdata = dmem_we ? store_lanes : 32'h0;

    assign wb_valid = (state == ST_RESP);
    assign wb_rd    = req_q.rd;

    lsu_load_align u_load_align (
        .rdata  (rdata_q),
        .addr   (req_q.addr[1:0]),
        .size   (req_q.size),
        .umload (req_q.umload),
        .data   (wb_data)
    );

endmodule

// File: tb/tb_rv32i_lsu.sv
// Directed bench for rv32i_lsu: stores, loads, misalignment, illegal op, timeout, reset and busy handling.
// Inputs are driven and outputs sampled 1ns after each rising edge.
module tb_rv32i_lsu;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  mem_wen = 3'b000;
    logic [2:0]  mem_ren = 3'b000;
    logic        umload = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic [4:0]  rd_addr = 5'd0;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack = 1'b0;
    logic [31:0] dmem_rdata = 32'h0;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        st_done;
    logic        misaligned;
    logic        illegal;
    logic        bus_err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rv32i_lsu #(.ACK_TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .mem_wen    (mem_wen),
        .mem_ren    (mem_ren),
        .umload     (umload),
        .addr       (addr),
        .wdata      (wdata),
        .rd_addr    (rd_addr),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_be    (dmem_be),
        .dmem_wdata (dmem_wdata),
        .dmem_ack   (dmem_ack),
        .dmem_rdata (dmem_rdata),
        .wb_valid   (wb_valid),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .st_done    (st_done),
        .misaligned (misaligned),
        .illegal    (illegal),
        .bus_err    (bus_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] wen, input logic [2:0] ren, input logic um,
                         input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd);
        req_valid = 1'b1;
        mem_wen   = wen;
        mem_ren   = ren;
        umload    = um;
        addr      = a;
        wdata     = wd;
        rd_addr   = rd;
        tick();
        req_valid = 1'b0;
        mem_wen   = 3'b000;
        mem_ren   = 3'b000;
    endtask

    task automatic store_op(input string tag, input logic [2:0] wen, input logic [31:0] a,
                            input logic [31:0] wd, input logic [31:0] exp_addr,
                            input logic [3:0] exp_be, input logic [31:0] exp_wd);
        issue(wen, 3'b000, 1'b0, a, wd, 5'd0);
        check({tag, "_req"},   {31'b0, dmem_req},  32'd1);
        check({tag, "_we"},    {31'b0, dmem_we},   32'd1);
        check({tag, "_addr"},  dmem_addr,          exp_addr);
        check({tag, "_be"},    {28'b0, dmem_be},   {28'b0, exp_be});
        check({tag, "_wdata"}, dmem_wdata,         exp_wd);
        dmem_ack = 1'b1;
        tick();
        dmem_ack = 1'b0;
        check({tag, "_done"},  {31'b0, st_done},   32'd1);
        check({tag, "_rdy"},   {31'b0, req_ready}, 32'd1);
        tick();
        check({tag, "_done0"}, {31'b0, st_done},   32'd0);
    endtask

    task automatic load_op(input string tag, input logic [2:0] ren, input logic um,
                           input logic [31:0] a, input logic [31:0] rdat, input logic [4:0] rd,
                           input logic [3:0] exp_be, input logic [31:0] exp_dat);
        issue(3'b000, ren, um, a, 32'h0, rd);
        check({tag, "_req"}, {31'b0, dmem_req}, 32'd1);
        check({tag, "_we"},  {31'b0, dmem_we},  32'd0);
        check({tag, "_be"},  {28'b0, dmem_be},  {28'b0, exp_be});
        dmem_ack   = 1'b1;
        dmem_rdata = rdat;
        tick();
        dmem_ack   = 1'b0;
        dmem_rdata = 32'hDEAD_BEEF;
        check({tag, "_wbv"}, {31'b0, wb_valid}, 32'd1);
        check({tag, "_rd"},  {27'b0, wb_rd},    {27'b0, rd});
        check({tag, "_dat"}, wb_data,           exp_dat);
        tick();
        check({tag, "_wbv0"}, {31'b0, wb_valid},  32'd0);
        check({tag, "_rdy"},  {31'b0, req_ready}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   req_cycles;
        logic seen;
        logic bad;
        int   n;

        tick();
        tick();
        check("rst_ready", {31'b0, req_ready}, 32'd1);
        check("rst_req",   {31'b0, dmem_req},  32'd0);
        check("rst_we",    {31'b0, dmem_we},   32'd0);
        check("rst_pulse", {28'b0, st_done, misaligned, illegal, bus_err}, 32'd0);
        check("rst_wbv",   {31'b0, wb_valid},  32'd0);
        check("rst_addr",  dmem_addr,          32'd0);
        check("rst_be",    {28'b0, dmem_be},   32'd0);
        check("rst_wdata", dmem_wdata,         32'd0);
        check("rst_wbdat", wb_data,            32'd0);
        check("rst_wbrd",  {27'b0, wb_rd},     32'd0);
        rst = 1'b0;
        tick();

        store_op("sb",  3'b001, 32'h0000_1003, 32'h0000_00A5, 32'h0000_1000, 4'b1000, 32'hA5A5_A5A5);
        store_op("sh",  3'b010, 32'h0000_2002, 32'h1234_ABCD, 32'h0000_2000, 4'b1100, 32'hABCD_ABCD);
        store_op("sw",  3'b100, 32'h0000_0010, 32'h1234_ABCD, 32'h0000_0010, 4'b1111, 32'h1234_ABCD);

        load_op("lb",   3'b001, 1'b0, 32'h0000_2002, 32'h12F0_3456, 5'd5,  4'b0100, 32'hFFFF_FFF0);
        load_op("lbu",  3'b001, 1'b1, 32'h0000_2002, 32'h12F0_3456, 5'd6,  4'b0100, 32'h0000_00F0);
        load_op("lh0",  3'b010, 1'b0, 32'h0000_2000, 32'h8001_7FFF, 5'd9,  4'b0011, 32'h0000_7FFF);
        load_op("lh2",  3'b010, 1'b0, 32'h0000_2002, 32'h8001_7FFF, 5'd10, 4'b1100, 32'hFFFF_8001);
        load_op("lhu2", 3'b010, 1'b1, 32'h0000_2002, 32'h8001_7FFF, 5'd11, 4'b1100, 32'h0000_8001);
        load_op("lw",   3'b100, 1'b0, 32'h0000_2004, 32'h89AB_CDEF, 5'd31, 4'b1111, 32'h89AB_CDEF);

        // Misaligned halfword and word loads never reach the bus.
        issue(3'b000, 3'b010, 1'b0, 32'h0000_3001, 32'h0, 5'd3);
        check("mis_h_pulse", {31'b0, misaligned}, 32'd1);
        check("mis_h_rdy",   {31'b0, req_ready},  32'd1);
        bad = dmem_req | wb_valid;
        for (int i = 0; i < 4; i++) begin
            tick();
            bad |= dmem_req | wb_valid | misaligned;
        end
        check("mis_h_quiet", {31'b0, bad}, 32'd0);
        issue(3'b000, 3'b100, 1'b0, 32'h0000_3002, 32'h0, 5'd3);
        check("mis_w_pulse", {31'b0, misaligned}, 32'd1);
        check("mis_w_req",   {31'b0, dmem_req},   32'd0);
        tick();

        issue(3'b011, 3'b000, 1'b0, 32'h0000_4000, 32'h0, 5'd0);
        check("ill_pulse", {31'b0, illegal},   32'd1);
        check("ill_req",   {31'b0, dmem_req},  32'd0);
        check("ill_rdy",   {31'b0, req_ready}, 32'd1);
        tick();
        check("ill_pulse0", {31'b0, illegal},  32'd0);
        check("ill_req0",   {31'b0, dmem_req}, 32'd0);

        // Timeout: ack is withheld, request must be dropped after TO cycles.
        issue(3'b000, 3'b100, 1'b0, 32'h0000_4000, 32'h0, 5'd4);
        req_cycles = 0;
        seen       = 1'b0;
        bad        = 1'b0;
        n          = 0;
        while (!seen && n < 20) begin
            if (bus_err) begin
                seen = 1'b1;
                check("to_rdy", {31'b0, req_ready}, 32'd1);
                check("to_req", {31'b0, dmem_req},  32'd0);
            end else begin
                if (dmem_req) req_cycles++;
                bad |= wb_valid;
                tick();
                n++;
            end
        end
        check("to_seen",   {31'b0, seen}, 32'd1);
        check("to_cycles", req_cycles,    TO);
        check("to_nowb",   {31'b0, bad},  32'd0);
        tick();
        check("to_pulse0", {31'b0, bus_err}, 32'd0);

        // Reset while waiting for ack; a late ack must not produce anything.
        issue(3'b000, 3'b100, 1'b0, 32'h0000_5000, 32'h0, 5'd12);
        check("rmid_req", {31'b0, dmem_req}, 32'd1);
        tick();
        rst = 1'b1;
        tick();
        check("rmid_drop", {31'b0, dmem_req}, 32'd0);
        rst        = 1'b0;
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h5555_AAAA;
        tick();
        dmem_ack = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bad |= wb_valid | st_done | bus_err | dmem_req;
            tick();
        end
        check("rmid_quiet", {31'b0, bad},       32'd0);
        check("rmid_rdy",   {31'b0, req_ready}, 32'd1);

        // Busy: req_valid held high through a load; the next op waits for IDLE.
        req_valid = 1'b1;
        mem_ren   = 3'b100;
        addr      = 32'h0000_6000;
        rd_addr   = 5'd7;
        tick();
        mem_ren   = 3'b000;
        mem_wen   = 3'b100;
        addr      = 32'h0000_7000;
        wdata     = 32'h1122_3344;
        rd_addr   = 5'd0;
        tick();
        check("busy_addr", dmem_addr,          32'h0000_6000);
        check("busy_we",   {31'b0, dmem_we},   32'd0);
        check("busy_rdy",  {31'b0, req_ready}, 32'd0);
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hCAFE_BABE;
        tick();
        dmem_ack = 1'b0;
        check("busy_wbv", {31'b0, wb_valid},  32'd1);
        check("busy_dat", wb_data,            32'hCAFE_BABE);
        check("busy_rd",  {27'b0, wb_rd},     32'd7);
        check("busy_rdy2", {31'b0, req_ready}, 32'd0);
        tick();
        check("busy_idle", {31'b0, req_ready}, 32'd1);
        check("busy_noq",  {31'b0, dmem_req},  32'd0);
        tick();
        req_valid = 1'b0;
        mem_wen   = 3'b000;
        check("busy2_req",  {31'b0, dmem_req}, 32'd1);
        check("busy2_we",   {31'b0, dmem_we},  32'd1);
        check("busy2_addr", dmem_addr,         32'h0000_7000);
        check("busy2_be",   {28'b0, dmem_be},  32'h0000_000F);
        dmem_ack = 1'b1;
        tick();
        dmem_ack = 1'b0;
        check("busy2_done", {31'b0, st_done}, 32'd1);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
